// File: rtl/spi_master.sv
// Mode-0 SPI master: one frame of {addr,rw}, TURN_CYC dummy periods, a data byte, then TAIL_CYC idle periods.
// Optional overrun flag when compiled with SPI_MASTER_OVERRUN_EN.
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int TURN_CYC = 3,
    parameter int TAIL_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       cs_pin,
    output logic       sclk_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
`ifdef SPI_MASTER_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CS_SETUP = 3'd1;
    localparam logic [2:0] ADDR     = 3'd2;
    localparam logic [2:0] TURN     = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] TAIL     = 3'd5;
    localparam logic [2:0] CS_HOLD  = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
    localparam logic [3:0] TAIL_LAST = 4'(TAIL_CYC - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] div_cnt;
    logic       phase;
    logic [3:0] per_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] wdata_q;
    logic       rw_q;
    logic       tick;
    logic       per_end;
    logic       shift_state;

    // phase is the SCLK level within the current period; a period ends on the tick that would drop it
    assign tick        = (state != IDLE) && (state != DONE) && (div_cnt == DIV_LAST);
    assign per_end     = tick && phase;
    assign shift_state = (state == ADDR) || (state == TURN) || (state == DATA) || (state == TAIL);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = CS_SETUP;
            CS_SETUP: if (per_end) state_nxt = ADDR;
            ADDR:     if (per_end && per_cnt == 4'd7) state_nxt = (TURN_CYC == 0) ? DATA : TURN;
            TURN:     if (per_end && per_cnt == TURN_LAST) state_nxt = DATA;
            DATA:     if (per_end && per_cnt == 4'd7) state_nxt = (TAIL_CYC == 0) ? CS_HOLD : TAIL;
            TAIL:     if (per_end && per_cnt == TAIL_LAST) state_nxt = CS_HOLD;
            CS_HOLD:  if (per_end) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            phase    <= 1'b0;
            per_cnt  <= 4'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            wdata_q  <= 8'd0;
            rw_q     <= 1'b0;
            rdata    <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_pin   <= 1'b1;
            sclk_pin <= 1'b0;
            mosi_pin <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;

            if (state_nxt != state) begin
                div_cnt <= 8'd0;
                phase   <= 1'b0;
                per_cnt <= 4'd0;
            end else if (tick) begin
                div_cnt <= 8'd0;
                phase   <= ~phase;
                if (phase) per_cnt <= per_cnt + 4'd1;
            end else if (state != IDLE) begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (tick && shift_state) sclk_pin <= ~phase;

            case (state)
                IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        wdata_q <= wdata;
                        tx_sh   <= {addr, rw};
                        rx_sh   <= 8'd0;
                        cs_pin  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CS_SETUP: begin
                    if (state_nxt == ADDR) begin
                        mosi_pin <= tx_sh[7];
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                    end
                end
                ADDR: begin
                    if (per_end) begin
                        if (state_nxt == ADDR) begin
                            mosi_pin <= tx_sh[7];
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                        end else if (state_nxt == DATA) begin
                            mosi_pin <= rw_q ? 1'b0 : wdata_q[7];
                            tx_sh    <= {wdata_q[6:0], 1'b0};
                        end else begin
                            mosi_pin <= 1'b0;
                        end
                    end
                end
                TURN: begin
                    if (state_nxt == DATA) begin
                        mosi_pin <= rw_q ? 1'b0 : wdata_q[7];
                        tx_sh    <= {wdata_q[6:0], 1'b0};
                    end
                end
                DATA: begin
                    // slave shifts on the falling edge, so MISO is stable at our rising tick
                    if (tick && !phase && rw_q) rx_sh <= {rx_sh[6:0], miso_pin};
                    if (per_end) begin
                        if (state_nxt == DATA) begin
                            mosi_pin <= rw_q ? 1'b0 : tx_sh[7];
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                        end else begin
                            mosi_pin <= 1'b0;
                        end
                    end
                end
                CS_HOLD: begin
                    if (state_nxt == DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if (rw_q) rdata <= rx_sh;
                    end
                end
                DONE: begin
                    cs_pin <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_MASTER_OVERRUN_EN
    // sticky until reset: a request arrived while a frame was in flight and was dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun <= 1'b0;
        else if (start && busy) overrun <= 1'b1;
    end
`endif

endmodule
